// File: rtl/fcmp_pkg.sv
// Shared definitions for the float-compare arbiter slice.
//   - opcode encodings used on req_op
//   - the word returned for a true compare
//   - default requester count
//   - NaN / zero classification helpers for IEEE-754 single precision
package fcmp_pkg;

  localparam int NUM_REQ_DEFAULT = 4;

  localparam logic [1:0] OP_EQ   = 2'b00;
  localparam logic [1:0] OP_LT   = 2'b01;
  localparam logic [1:0] OP_LE   = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [31:0] CMP_TRUE = 32'h1;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  // Magnitude zero, sign ignored.
  function automatic logic fp_is_zero(input logic [31:0] x);
    return x[30:0] == 31'h0;
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational IEEE-754 single-precision comparator.
// Ports:
//   a, b   : operands
//   op     : OP_EQ / OP_LT / OP_LE / OP_RSVD
//   result : 1 when the selected relation holds; always 0 for NaN inputs
//            and for the reserved opcode
module fcmp_core
  import fcmp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic        result
);

  logic any_nan;
  logic both_zero;
  logic eq;
  logic lt;

  always_comb begin
    any_nan   = fp_is_nan(a) || fp_is_nan(b);
    both_zero = fp_is_zero(a) && fp_is_zero(b);
    eq        = (a == b) || both_zero;

    // Sign-magnitude ordering: for negatives the larger magnitude is smaller.
    if (both_zero) begin
      lt = 1'b0;
    end else if (a[31] != b[31]) begin
      lt = a[31];
    end else if (!a[31]) begin
      lt = a[30:0] < b[30:0];
    end else begin
      lt = a[30:0] > b[30:0];
    end

    case (op)
      OP_EQ:   result = eq;
      OP_LT:   result = lt;
      OP_LE:   result = lt || eq;
      default: result = 1'b0;
    endcase

    if (any_nan) begin
      result = 1'b0;
    end
  end

endmodule

// File: rtl/fcmp_arbiter.sv
// Round-robin arbiter sharing one float comparator among NUM_REQ requesters,
// with a single registered response slot (1-cycle latency, 1 compare/cycle).
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   req_valid / req_ready : per-requester handshake (req_ready one-hot or 0)
//   req_op, req_a, req_b  : per-requester opcode and operands, packed by index
//   rsp_valid / rsp_ready : response handshake
//   rsp_tag, rsp_data     : owning requester and compare result (0 or 1)
//
// state    | meaning
// ---------+--------------------------------------------
// ST_EMPTY | no response held, any grant may load slot
// ST_FULL  | response held until rsp_ready
module fcmp_arbiter
  import fcmp_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [31:0]          rsp_data
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [TAG_W-1:0] last_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;

  logic [TAG_W-1:0] grant_idx;
  logic             found;
  logic             slot_free;
  logic             hs;
  logic             cmp_res;

  logic [31:0] a_arr  [NUM_REQ];
  logic [31:0] b_arr  [NUM_REQ];
  logic [1:0]  op_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*32 +: 32];
    assign b_arr[i]  = req_b[i*32 +: 32];
    assign op_arr[i] = req_op[i*2 +: 2];
  end

  function automatic logic [TAG_W-1:0] rr_idx(input logic [TAG_W-1:0] base, input int off);
    return TAG_W'((int'(base) + off) % NUM_REQ);
  endfunction

  // Search from last_grant+1; offset NUM_REQ revisits last_grant itself last.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!found && req_valid[rr_idx(last_q, off)]) begin
        found     = 1'b1;
        grant_idx = rr_idx(last_q, off);
      end
    end
  end

  // rst_n gates the grant so nothing is offered while reset is held.
  assign slot_free = (state_q == ST_EMPTY) || rsp_ready;
  assign hs        = found && slot_free && rst_n;
  assign req_ready = hs ? (NUM_REQ'(1) << grant_idx) : '0;

  fcmp_core u_core (
    .a      (a_arr[grant_idx]),
    .b      (b_arr[grant_idx]),
    .op     (op_arr[grant_idx]),
    .result (cmp_res)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (hs) state_d = ST_FULL;
      ST_FULL:  if (!hs && rsp_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      last_q  <= TAG_W'(NUM_REQ - 1);
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        last_q <= grant_idx;
        tag_q  <= grant_idx;
        data_q <= cmp_res ? CMP_TRUE : 32'h0;
      end
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_tag   = tag_q;
  assign rsp_data  = data_q;

endmodule

// File: tb/tb_fcmp_arbiter.sv
module tb_fcmp_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_tag;
  logic [31:0]     rsp_data;

  int errors = 0;
  int checks = 0;

  fcmp_arbiter #(.NUM_REQ(N), .TAG_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model (real-number semantics) ----------------
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    real v;
    if (x[30:23] == 8'hFF) begin
      d = {x[31], 11'h7FF, 52'b0};
      return $bitstoreal(d);
    end
    if (x[30:23] == 8'h00) begin
      v = real'(x[22:0]);
      for (int k = 0; k < 149; k++) v = v * 0.5;
      return x[31] ? -v : v;
    end
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] model_cmp(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    real ra, rb;
    logic r;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 32'h0;
    ra = f2r(a);
    rb = f2r(b);
    case (op)
      2'd0:    r = (ra == rb);
      2'd1:    r = (ra < rb);
      2'd2:    r = (ra <= rb);
      default: r = 1'b0;
    endcase
    return {31'b0, r};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = 32'h0000_0000;
      1: v = 32'h8000_0000;
      2: v = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      3: v = 32'h7F80_0000;
      4: v = 32'hFF80_0000;
      5: v = {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
      6: v = 32'h3F80_0000;
      7: v = 32'hBF80_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[i*2 +: 2] = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // Present one request on requester i with rsp_ready=1 and leave the bench at
  // the next falling edge, where the response is visible.
  task automatic issue(input int i, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    set_req(i, op, a, b);
    req_valid = '0;
    req_valid[i] = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_tag !== 2'd0) begin errors++; $display("FAIL reset_rsp_tag got=%0d exp=0", rsp_tag); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  // Directly after reset: grants must start at requester 0 on the first edge.
  task automatic test_round_robin();
    logic [31:0] exp_d [N];
    for (int i = 0; i < N; i++) begin
      set_req(i, 2'(i % 3), 32'h3F80_0000 + 32'(i << 20), 32'h3FC0_0000);
      exp_d[i] = model_cmp(2'(i % 3), 32'h3F80_0000 + 32'(i << 20), 32'h3FC0_0000);
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got=%b exp=0001", req_ready); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_tag !== 2'(k % N) || rsp_data !== exp_d[k % N]) begin
        errors++;
        $display("FAIL rr_cycle%0d got v=%b tag=%0d d=%h exp v=1 tag=%0d d=%h",
                 k, rsp_valid, rsp_tag, rsp_data, k % N, exp_d[k % N]);
      end
    end
    req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_single();
    issue(0, 2'b01, 32'h3F80_0000, 32'h4000_0000);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 2'd0 || rsp_data !== 32'h1) begin
      errors++;
      $display("FAIL single_lt got v=%b tag=%0d d=%h exp v=1 tag=0 d=1", rsp_valid, rsp_tag, rsp_data);
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_signed_zero_nan();
    issue(0, 2'b00, 32'h0000_0000, 32'h8000_0000);
    checks++; if (rsp_data !== 32'h1) begin errors++; $display("FAIL eq_signed_zero got=%h exp=1", rsp_data); end
    issue(0, 2'b10, 32'h7FC0_0000, 32'h3F80_0000);
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL le_nan got=%h exp=0", rsp_data); end
    issue(0, 2'b11, 32'h3F80_0000, 32'h3F80_0000);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      errors++; $display("FAIL rsvd_op got v=%b d=%h exp v=1 d=0", rsp_valid, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_neg_order();
    issue(0, 2'b01, 32'hC000_0000, 32'hBF80_0000);
    checks++; if (rsp_data !== 32'h1) begin errors++; $display("FAIL lt_negative got=%h exp=1", rsp_data); end
    issue(0, 2'b10, 32'hBF80_0000, 32'hC000_0000);
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL le_negative_swapped got=%h exp=0", rsp_data); end
    @(negedge clk);
  endtask

  // Last grant before this test is requester 0, so the held response is 1, then 2.
  task automatic test_backpressure();
    logic [31:0] exp_d [N];
    logic [1:0]  held_tag;
    logic [31:0] held_data;
    for (int i = 0; i < N; i++) begin
      set_req(i, 2'b10, 32'h4000_0000 - 32'(i << 22), 32'h3F80_0000);
      exp_d[i] = model_cmp(2'b10, 32'h4000_0000 - 32'(i << 22), 32'h3F80_0000);
    end
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    @(negedge clk);
    held_tag = rsp_tag;
    held_data = rsp_data;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 2'd1 || rsp_data !== exp_d[1]) begin
      errors++;
      $display("FAIL bp_first got v=%b tag=%0d d=%h exp v=1 tag=1 d=%h", rsp_valid, rsp_tag, rsp_data, exp_d[1]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_ready !== 4'h0 || rsp_valid !== 1'b1 || rsp_tag !== held_tag || rsp_data !== held_data) begin
        errors++;
        $display("FAIL bp_hold%0d got rdy=%b v=%b tag=%0d d=%h exp rdy=0000 v=1 tag=%0d d=%h",
                 k, req_ready, rsp_valid, rsp_tag, rsp_data, held_tag, held_data);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 2'd2 || rsp_data !== exp_d[2]) begin
      errors++;
      $display("FAIL bp_next got v=%b tag=%0d d=%h exp v=1 tag=2 d=%h", rsp_valid, rsp_tag, rsp_data, exp_d[2]);
    end
    @(negedge clk);
  endtask

  // Last grant is 2 on entry; a grant to 1 makes 2 the next winner unless reset restores priority.
  task automatic test_reset_mid();
    set_req(0, 2'b00, 32'h4040_0000, 32'h4040_0000);
    set_req(1, 2'b00, 32'h4040_0000, 32'h4040_0000);
    set_req(2, 2'b00, 32'h4040_0000, 32'h4040_0000);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 2'd1) begin
      errors++; $display("FAIL rmid_pending got v=%b tag=%0d exp v=1 tag=1", rsp_valid, rsp_tag); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_tag !== 2'd0 || rsp_data !== 32'h0) begin
      errors++; $display("FAIL rmid_async_clear got v=%b tag=%0d d=%h exp v=0 tag=0 d=0", rsp_valid, rsp_tag, rsp_data);
    end
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rmid_ready_in_reset got=%b exp=0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_priority got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 2'd0 || rsp_data !== 32'h1) begin
      errors++; $display("FAIL rmid_first_rsp got v=%b tag=%0d d=%h exp v=1 tag=0 d=1", rsp_valid, rsp_tag, rsp_data); end
    @(negedge clk);
  endtask

  // Random traffic against a transaction-level model of the slot and the
  // rotating priority.
  task automatic test_random();
    logic        m_valid;
    logic [1:0]  m_tag;
    logic [31:0] m_data;
    int          m_last;
    int          g;
    logic [N-1:0] exp_rdy;
    logic [31:0] a, b;
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0; m_tag = 2'd0; m_data = 32'h0; m_last = N - 1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      checks++;
      if (rsp_valid !== m_valid || (m_valid && (rsp_tag !== m_tag || rsp_data !== m_data))) begin
        errors++;
        $display("FAIL rand_rsp cyc=%0d got v=%b tag=%0d d=%h exp v=%b tag=%0d d=%h",
                 cyc, rsp_valid, rsp_tag, rsp_data, m_valid, m_tag, m_data);
      end
      for (int i = 0; i < N; i++) begin
        a = rand_fp();
        case ($urandom_range(0, 3))
          0: b = a;
          1: b = {~a[31], a[30:0]};
          default: b = rand_fp();
        endcase
        set_req(i, 2'($urandom_range(0, 3)), a, b);
      end
      req_valid = N'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      if (!m_valid || rsp_ready)
        for (int k = 1; k <= N; k++)
          if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
      exp_rdy = (g >= 0) ? N'(1 << g) : '0;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
      end
      if (g >= 0) begin
        m_valid = 1'b1;
        m_tag   = 2'(g);
        m_data  = model_cmp(req_op[g*2 +: 2], req_a[g*32 +: 32], req_b[g*32 +: 32]);
        m_last  = g;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_single();
    test_signed_zero_nan();
    test_neg_order();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fcmp_arbiter.md
FCMP_ARBITER -- requirements
Module: fcmp_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one float compare datapath.
REQ-002 Parameter TAG_W, default 2, width of the requester index, equal to clog2(NUM_REQ).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit set per cycle.
REQ-007 req_op  input  2*NUM_REQ  per-requester opcode: 00 EQ, 01 LT, 10 LE, 11 reserved.
REQ-008 req_a  input  32*NUM_REQ  per-requester IEEE-754 single-precision operand A.
REQ-009 req_b  input  32*NUM_REQ  per-requester IEEE-754 single-precision operand B.
REQ-010 rsp_valid  output  1  response valid.
REQ-011 rsp_ready  input  1  response consumer ready.
REQ-012 rsp_tag  output  TAG_W  index of the requester that owns the response.
REQ-013 rsp_data  output  32  compare result: 32'h1 if true, 32'h0 if false.

Function
REQ-014 A handshake on requester i occurs in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-015 req_ready is combinational. The granted bit goes high only when the output slot is free: rsp_valid==0, or rsp_valid==1 and rsp_ready==1 in the same cycle.
REQ-016 Arbitration is round-robin. Search starts at index last_grant+1 and wraps modulo NUM_REQ. The first index with req_valid set wins.
REQ-017 last_grant updates only on an accepted handshake. It holds when no request is present or when the slot is blocked.
REQ-018 Two-state FSM:
- EMPTY to FULL on a handshake.
- FULL to EMPTY on rsp_ready with no new handshake.
- FULL stays FULL when rsp_ready and a new handshake occur together (back-to-back).
- FULL stays FULL when rsp_ready is 0.
REQ-019 Latency is 1 cycle: operands are accepted in cycle N; rsp_valid, rsp_tag and rsp_data are registered and visible in cycle N+1. Throughput is 1 compare per cycle.
REQ-020 While rsp_valid is 1 and rsp_ready is 0, rsp_tag and rsp_data hold stable and every req_ready bit is 0.
REQ-021 NaN means exponent 8'hFF and mantissa nonzero. If either operand is NaN, every op returns 0.
REQ-022 EQ is true when the operands are bitwise equal, or both are zero of either sign (+0 == -0).
REQ-023 LT is exact IEEE ordering with no tolerance, and is false when both operands are zero:
- sign bits differ: true when A is negative;
- both positive: true when A[30:0] < B[30:0] (unsigned);
- both negative: true when A[30:0] > B[30:0] (unsigned).
REQ-024 LE = LT or EQ.
REQ-025 Reserved opcode 11 is accepted like any other op and returns 32'h0.
REQ-026 A requester that drops req_valid before its grant loses nothing. No request is latched before its handshake.
REQ-027 rsp_data bits [31:1] are always 0.

Reset
REQ-028 While rst_n is low:
- FSM is EMPTY; rsp_valid=0, rsp_tag=0, rsp_data=32'h0;
- last_grant = NUM_REQ-1, so requester 0 has first priority after reset;
- req_ready = 0.
REQ-029 Reset asserted mid-operation discards any pending response immediately, with no handshake and no partial output.
REQ-030 The first handshake is possible in the first rising edge after rst_n deasserts.

Structure
REQ-031 Shared package fcmp_pkg holds:
- opcode constants OP_EQ, OP_LT, OP_LE, OP_RSVD;
- constant CMP_TRUE = 32'h1;
- the default NUM_REQ.
REQ-032 One sub-module, fcmp_core: purely combinational, inputs a, b, op; output 1-bit result; implements REQ-021 to REQ-025.
REQ-033 Arbiter, FSM and output register live in fcmp_arbiter. There are no other sub-modules.

Verification
REQ-034 Single request, no backpressure:
- stimulus: req 0 op LT, A=0x3F800000 (1.0), B=0x40000000 (2.0), rsp_ready=1;
- response: next cycle rsp_valid=1, tag=0, data=0x1.
REQ-035 Signed zero and NaN:
- op EQ, A=0x00000000, B=0x80000000 -> data=0x1;
- op LE, A=0x7FC00000, B=0x3F800000 -> data=0x0.
REQ-036 Negative ordering:
- op LT, A=0xC0000000 (-2.0), B=0xBF800000 (-1.0) -> 0x1;
- same operands, op LE with A/B swapped -> 0x0.
REQ-037 Round-robin fairness:
- stimulus: all 4 requesters valid continuously, rsp_ready=1;
- response: tags 0,1,2,3,0,... on consecutive cycles, one response per cycle.
REQ-038 Backpressure:
- stimulus: rsp_ready=0 for 3 cycles with requests pending;
- response: rsp_data and rsp_tag stable, req_ready=0;
- then rsp_ready=1 -> same-cycle handshake, and a new response the following cycle.
REQ-039 Reset mid-operation:
- stimulus: rst_n low while rsp_valid=1;
- response: rsp_valid=0 asynchronously;
- after release with requester 2 and requester 0 both valid -> requester 0 is granted first.
